// File: rtl/picorv32_axi_responder.sv
// AXI4-Lite slave that terminates a picorv32-style AXI memory port and replays
// each transaction on a native valid/ready memory bus, one at a time.
module picorv32_axi_responder #(
  parameter logic [31:0] ADDR_MASK  = 32'hFFFF_FFFF,
  parameter bit          WORD_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP} state_t;

  state_t      state;
  logic        aw_full, w_full, ar_full;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [3:0]  w_strb;
  logic        ar_instr;
  logic        aw_hs, w_hs, ar_hs;
  logic        unused_ok;

  // Handshake contract: a channel transfers on the edge where valid && ready
  // are both high; valid-side holds its payload until then, and each holding
  // register refuses new traffic (ready low) until its transaction completes.
  assign mem_axi_awready = !rst && !aw_full;
  assign mem_axi_wready  = !rst && !w_full;
  assign mem_axi_arready = !rst && !ar_full;

  assign aw_hs = mem_axi_awvalid && mem_axi_awready;
  assign w_hs  = mem_axi_wvalid  && mem_axi_wready;
  assign ar_hs = mem_axi_arvalid && mem_axi_arready;

  assign dbg_state = state;
  assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot[1:0]};

  function automatic logic [31:0] xlate(input logic [31:0] a);
    logic [31:0] t;
    t = a & ADDR_MASK;
    if (WORD_ALIGN) t[1:0] = 2'b00;
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      ar_full        <= 1'b0;
      aw_addr        <= '0;
      ar_addr        <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      ar_instr       <= 1'b0;
      mem_valid      <= 1'b0;
      mem_instr      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      mem_axi_bvalid <= 1'b0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= mem_axi_awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= mem_axi_wdata;
        w_strb <= mem_axi_wstrb;
      end
      if (ar_hs) begin
        ar_full  <= 1'b1;
        ar_addr  <= mem_axi_araddr;
        ar_instr <= mem_axi_arprot[2];
      end

      // Full holding registers never see a handshake, so the clears below
      // cannot collide with the captures above.
      case (state)
        IDLE: begin
          if (aw_full && w_full) begin
            state     <= WR_REQ;
            mem_valid <= 1'b1;
            mem_instr <= 1'b0;
            mem_addr  <= xlate(aw_addr);
            mem_wdata <= w_data;
            mem_wstrb <= w_strb;
          end else if (ar_full) begin
            state     <= RD_REQ;
            mem_valid <= 1'b1;
            mem_instr <= ar_instr;
            mem_addr  <= xlate(ar_addr);
            mem_wstrb <= 4'b0000;
          end
        end
        RD_REQ: begin
          if (mem_ready) begin
            state          <= RD_RESP;
            mem_valid      <= 1'b0;
            mem_axi_rdata  <= mem_rdata;
            mem_axi_rvalid <= 1'b1;
          end
        end
        RD_RESP: begin
          if (mem_axi_rready) begin
            state          <= IDLE;
            mem_axi_rvalid <= 1'b0;
            ar_full        <= 1'b0;
          end
        end
        WR_REQ: begin
          if (mem_ready) begin
            state          <= WR_RESP;
            mem_valid      <= 1'b0;
            mem_axi_bvalid <= 1'b1;
          end
        end
        WR_RESP: begin
          if (mem_axi_bready) begin
            state          <= IDLE;
            mem_axi_bvalid <= 1'b0;
            aw_full        <= 1'b0;
            w_full         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_axi_responder.sv
// Directed bench for picorv32_axi_responder: reads, writes, back-pressure,
// contention, reset mid-read, and a second instance with a narrowed ADDR_MASK.
module tb_picorv32_axi_responder;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_errors = 0;

  // default instance
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  dbg_state;

  // masked instance
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_mem_valid, m_mem_instr, m_mem_ready;
  logic [31:0] m_mem_addr, m_mem_wdata, m_mem_rdata;
  logic [3:0]  m_mem_wstrb;
  logic [2:0]  m_dbg_state;

  picorv32_axi_responder dut (
    .clk(clk), .rst(rst),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
    .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
    .mem_axi_rdata(rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  picorv32_axi_responder #(.ADDR_MASK(32'h0000_FFFF)) dut_m (
    .clk(clk), .rst(rst),
    .mem_axi_awvalid(m_awvalid), .mem_axi_awready(m_awready),
    .mem_axi_awaddr(m_awaddr), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(m_wvalid), .mem_axi_wready(m_wready),
    .mem_axi_wdata(m_wdata), .mem_axi_wstrb(m_wstrb),
    .mem_axi_bvalid(m_bvalid), .mem_axi_bready(m_bready),
    .mem_axi_arvalid(m_arvalid), .mem_axi_arready(m_arready),
    .mem_axi_araddr(m_araddr), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(m_rvalid), .mem_axi_rready(m_rready),
    .mem_axi_rdata(m_rdata),
    .mem_valid(m_mem_valid), .mem_instr(m_mem_instr), .mem_ready(m_mem_ready),
    .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata), .mem_wstrb(m_mem_wstrb),
    .mem_rdata(m_mem_rdata), .dbg_state(m_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_readies(input string tag, input logic exp);
    chk({tag, "_awready"}, {31'b0, awready}, {31'b0, exp});
    chk({tag, "_wready"},  {31'b0, wready},  {31'b0, exp});
    chk({tag, "_arready"}, {31'b0, arready}, {31'b0, exp});
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0;
    bready = 0; arvalid = 0; araddr = 0; arprot = 0; rready = 0;
    mem_ready = 0; mem_rdata = 0;
    m_awvalid = 0; m_awaddr = 0; m_wvalid = 0; m_wdata = 0; m_wstrb = 0;
    m_bready = 0; m_arvalid = 0; m_araddr = 0; m_rready = 0;
    m_mem_ready = 0; m_mem_rdata = 0;

    // reset state
    step(); step();
    chk_readies("rst", 1'b0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_instr", {31'b0, mem_instr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_state", {29'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    step();
    chk_readies("post_rst", 1'b1);

    // single instruction-fetch read, zero wait
    arvalid = 1; araddr = 32'h1000_0006; arprot = 3'b100;
    step();
    arvalid = 0;
    chk("rd1_arready_busy", {31'b0, arready}, 32'd0);
    chk("rd1_mem_valid_n1", {31'b0, mem_valid}, 32'd0);
    step();
    chk("rd1_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("rd1_mem_addr", mem_addr, 32'h1000_0004);
    chk("rd1_mem_instr", {31'b0, mem_instr}, 32'd1);
    chk("rd1_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 0; mem_rdata = 32'h0;
    chk("rd1_rvalid", {31'b0, rvalid}, 32'd1);
    chk("rd1_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd1_mem_valid_drop", {31'b0, mem_valid}, 32'd0);
    rready = 1;
    step();
    rready = 0;
    chk("rd1_rvalid_clr", {31'b0, rvalid}, 32'd0);
    chk("rd1_arready_back", {31'b0, arready}, 32'd1);

    // write with W three cycles before AW
    wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'b0011;
    step();
    wvalid = 0;
    chk("wr1_wready_busy", {31'b0, wready}, 32'd0);
    chk("wr1_awready_free", {31'b0, awready}, 32'd1);
    step();
    chk("wr1_idle_a", {31'b0, mem_valid}, 32'd0);
    step();
    chk("wr1_idle_b", {31'b0, mem_valid}, 32'd0);
    awvalid = 1; awaddr = 32'h0000_0020;
    step();
    awvalid = 0;
    chk("wr1_awready_busy", {31'b0, awready}, 32'd0);
    step();
    chk("wr1_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("wr1_mem_addr", mem_addr, 32'h0000_0020);
    chk("wr1_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("wr1_mem_wstrb", {28'b0, mem_wstrb}, 32'h3);
    chk("wr1_mem_instr", {31'b0, mem_instr}, 32'd0);
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("wr1_bvalid", {31'b0, bvalid}, 32'd1);
    chk("wr1_mem_valid_drop", {31'b0, mem_valid}, 32'd0);
    step();
    chk("wr1_bvalid_held", {31'b0, bvalid}, 32'd1);
    chk("wr1_awready_held", {31'b0, awready}, 32'd0);
    chk("wr1_wready_held", {31'b0, wready}, 32'd0);
    bready = 1;
    step();
    bready = 0;
    chk("wr1_bvalid_clr", {31'b0, bvalid}, 32'd0);
    chk("wr1_awready_back", {31'b0, awready}, 32'd1);
    chk("wr1_wready_back", {31'b0, wready}, 32'd1);

    // back-pressure: 3 memory wait cycles, rready low 5 cycles, second AR queued
    arvalid = 1; araddr = 32'h0000_0104; arprot = 3'b000;
    step();
    araddr = 32'h0000_0200;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_mem_valid_%0d", i), {31'b0, mem_valid}, 32'd1);
      chk($sformatf("bp_mem_addr_%0d", i), mem_addr, 32'h0000_0104);
      chk($sformatf("bp_arready_%0d", i), {31'b0, arready}, 32'd0);
      if (i < 3) step();
    end
    mem_ready = 1; mem_rdata = 32'hA5A5_0001;
    step();
    mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_rvalid_%0d", i), {31'b0, rvalid}, 32'd1);
      chk($sformatf("bp_rdata_%0d", i), rdata, 32'hA5A5_0001);
      chk($sformatf("bp_ar_blocked_%0d", i), {31'b0, arready}, 32'd0);
      step();
    end
    rready = 1;
    chk("bp_arready_at_rhs", {31'b0, arready}, 32'd0);
    step();
    rready = 0;
    chk("bp_rvalid_clr", {31'b0, rvalid}, 32'd0);
    chk("bp_arready_after", {31'b0, arready}, 32'd1);
    step();
    arvalid = 0;
    step();
    chk("bp2_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("bp2_mem_addr", mem_addr, 32'h0000_0200);
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ready = 0;
    chk("bp2_rdata", rdata, 32'h0BAD_F00D);
    rready = 1;
    step();
    rready = 0;

    // contention: AR and AW+W in the same cycle, write goes first
    arvalid = 1; araddr = 32'h0000_0300;
    awvalid = 1; awaddr = 32'h0000_0400;
    wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'b1111;
    step();
    arvalid = 0; awvalid = 0; wvalid = 0;
    chk_readies("ct_busy", 1'b0);
    step();
    chk("ct_wr_mem_addr", mem_addr, 32'h0000_0400);
    chk("ct_wr_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("ct_bvalid", {31'b0, bvalid}, 32'd1);
    chk("ct_rvalid_early", {31'b0, rvalid}, 32'd0);
    bready = 1;
    step();
    bready = 0;
    chk("ct_gap_mem_valid", {31'b0, mem_valid}, 32'd0);
    step();
    chk("ct_rd_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("ct_rd_mem_addr", mem_addr, 32'h0000_0300);
    chk("ct_rd_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    mem_ready = 1; mem_rdata = 32'h1122_3344;
    step();
    mem_ready = 0;
    chk("ct_rvalid", {31'b0, rvalid}, 32'd1);
    chk("ct_rdata", rdata, 32'h1122_3344);
    rready = 1;
    step();
    rready = 0;

    // write with all strobes clear still completes
    awvalid = 1; awaddr = 32'h0000_0700; wvalid = 1; wdata = 32'h0; wstrb = 4'b0000;
    step();
    awvalid = 0; wvalid = 0;
    step();
    chk("z_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("z_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("z_bvalid", {31'b0, bvalid}, 32'd1);
    bready = 1;
    step();
    bready = 0;

    // reset asserted during RD_REQ
    arvalid = 1; araddr = 32'h0000_0500;
    step();
    arvalid = 0;
    step();
    chk("rr_mem_valid_pre", {31'b0, mem_valid}, 32'd1);
    rst = 1'b1;
    mem_ready = 1; mem_rdata = 32'h7777_7777;
    step();
    mem_ready = 0;
    chk("rr_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rr_rvalid", {31'b0, rvalid}, 32'd0);
    chk_readies("rr_in_rst", 1'b0);
    rst = 1'b0;
    step();
    chk_readies("rr_after", 1'b1);
    step();
    chk("rr_no_resp", {31'b0, rvalid}, 32'd0);
    chk("rr_no_req", {31'b0, mem_valid}, 32'd0);
    arvalid = 1; araddr = 32'h0000_0600; arprot = 3'b000;
    step();
    arvalid = 0;
    step();
    chk("rr2_mem_addr", mem_addr, 32'h0000_0600);
    mem_ready = 1; mem_rdata = 32'h55AA_55AA;
    step();
    mem_ready = 0;
    chk("rr2_rvalid", {31'b0, rvalid}, 32'd1);
    chk("rr2_rdata", rdata, 32'h55AA_55AA);
    rready = 1;
    step();
    rready = 0;

    // ADDR_MASK = 0x0000_FFFF instance
    m_awvalid = 1; m_awaddr = 32'h8000_1234; m_wvalid = 1; m_wdata = 32'h0F0F_0F0F; m_wstrb = 4'b1100;
    step();
    m_awvalid = 0; m_wvalid = 0;
    step();
    chk("mask_mem_valid", {31'b0, m_mem_valid}, 32'd1);
    chk("mask_mem_addr", m_mem_addr, 32'h0000_1234);
    chk("mask_mem_wstrb", {28'b0, m_mem_wstrb}, 32'hC);
    m_mem_ready = 1;
    step();
    m_mem_ready = 0;
    chk("mask_bvalid", {31'b0, m_bvalid}, 32'd1);
    m_bready = 1;
    step();
    m_bready = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
